multiword_serial_adder: RTL and testbench
=========================================

# multiword_serial_adder

- Multi-cycle adder/subtractor for wide operands (W = N*CHUNKS bits).
- Accepts one operand pair per transaction over a valid/ready handshake.
- Each cycle it feeds one N-bit chunk, LSB chunk first, through the team's N-bit carry-skip adder, holding the inter-chunk carry in a flop.
- Sits upstream of and around that adder: it sequences the adder's operands and collects its sum/cout into a W-bit result returned over a second valid/ready handshake.

## Interface
- N, 16, adder slice width; multiple of 4
- CHUNKS, 4, number of slices per operand; ≥1; W = N*CHUNKS
- clk  input  1  clock, rising edge
- rst  input  1  reset rst, synchronous, active-high
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands
- in_a  input  W  operand A
- in_b  input  W  operand B
- in_cin  input  1  carry-in for add; ignored when in_sub=1
- in_sub  input  1  1: compute A−B (B inverted, carry-in forced 1)
- out_valid  output  1  result valid
- out_ready  input  1  consumer takes result
- out_sum  output  W  result, modulo 2^W
- out_cout  output  1  carry out of bit W−1 (for subtract: 1 = no borrow)
- busy  output  1  high in ADD or DONE

## Operation
FSM states:
- IDLE
  - in_ready=1.
  - On in_valid, latch A, B (inverted if in_sub), and carry (in_sub ? 1 : in_cin); clear idx and the result register; go to ADD.
- ADD
  - Present chunk idx of A/B and the carry flop to the adder slice.
  - Write the slice sum into result chunk idx; carry ← slice cout; idx++.
  - After the chunk CHUNKS−1 write, go to DONE.
- DONE
  - out_valid=1; out_sum = result, out_cout = carry flop, both held stable.
  - On out_ready, go to IDLE.

Rules:
- in_ready is high only in IDLE. Transactions never overlap, and a new pair is not accepted in the same cycle a result is taken.
- Operands are latched on acceptance; in_a/in_b/in_cin/in_sub may change afterwards with no effect.
- The adder slice's own reset input is tied 0. All clearing is done by this block's registers.
- idx width is max(1, $clog2(CHUNKS)). The last-chunk decision compares idx against CHUNKS−1, so CHUNKS=1 works.
- Reset (any state, including mid-ADD):
  - next cycle: state IDLE, in_ready=1, out_valid=0, busy=0, out_sum=0, out_cout=0, idx=0, carry=0;
  - the partial result is discarded.
- rst has priority over every handshake in the same cycle.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, out_sum=0, out_cout=0.
- Acceptance on edge E0 (in_valid & in_ready). in_ready low from E0.
- ADD occupies the CHUNKS cycles after E0. out_valid rises after edge E0+CHUNKS (latency = CHUNKS cycles).
- Result taken on edge E1 (out_valid & out_ready). in_ready=1 from E1.
- Best-case throughput: one transaction per CHUNKS+2 cycles.
- Back-pressure: out_valid, out_sum and out_cout are unchanged for as long as out_ready=0. There is no timeout.
- Critical path is one N-bit carry-skip slice plus mux/register, never the full W bits.

## Structure
- Shared package holds:
  - state enum {IDLE, ADD, DONE};
  - W as a derived localparam;
  - helper function for idx width.
- One sub-module: top_carry_skip_adder #(.N(N)), instantiated once as the chunk adder, rst port tied 0.
- Everything else (FSM, operand/result registers, chunk muxes, carry flop) is in this module.

## Test plan
All scenarios use N=16, CHUNKS=4 (W=64).
1. A=0x0000_0000_0000_FFFF, B=0x1, cin=0, sub=0 → out_sum=0x0000_0000_0001_0000, out_cout=0; out_valid exactly 4 cycles after acceptance.
2. A=0xFFFF_FFFF_FFFF_FFFF, B=0x1, cin=0 → out_sum=0, out_cout=1 (carry ripples across all chunk boundaries).
3. A=0x5, B=0x7, sub=1, cin=1 (ignored) → out_sum=0xFFFF_FFFF_FFFF_FFFE, out_cout=0. Then A=0x7, B=0x5, sub=1 → out_sum=0x2, out_cout=1.
4. A=0x1234_5678_9ABC_DEF0, B=0x0FED_CBA9_8765_4321, cin=1; out_ready held 0 for 10 cycles → out_valid, out_sum=0x2222_2222_2222_2212 and out_cout=0 all stable, in_ready=0 throughout. out_ready=1 → in_ready=1 next cycle. A back-to-back in_valid is accepted only then.
5. rst pulsed during the third ADD cycle → next cycle in_ready=1, out_valid=0, out_sum=0, busy=0. A following 0x1+0x1 transaction yields 0x2, out_cout=0.
6. Random A/B/cin/sub for 1,000 transactions with random out_ready stalls → every result equals a 65-bit golden model; no transaction lost or duplicated.

Source files
------------

// File: rtl/multiword_serial_adder_pkg.sv
// Shared types and sizing helpers for the multi-word serial adder.
// The FSM state encoding and the chunk-index width rule live here.
package multiword_serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int N_DEFAULT      = 16;
    localparam int CHUNKS_DEFAULT = 4;
    localparam int W_DEFAULT      = N_DEFAULT * CHUNKS_DEFAULT;

    // A single-chunk adder still needs a one-bit index register.
    function automatic int idx_width(input int chunks);
        return (chunks > 1) ? $clog2(chunks) : 1;
    endfunction

endpackage

// File: rtl/top_carry_skip_adder.sv
// N-bit carry-skip adder: 4-bit ripple blocks, each with a skip mux that forwards
// the block carry-in when every bit of the block propagates.
module top_carry_skip_adder #(
    parameter int N = 16
) (
    input  logic         rst,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);
    localparam int NB = N / 4;

    logic [N-1:0] p;
    logic [N-1:0] g;
    logic [N-1:0] raw_sum;
    logic [NB:0]  block_carry;

    assign p = a ^ b;
    assign g = a & b;
    assign block_carry[0] = cin;

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_block
            logic [4:0] rc;
            assign rc[0] = block_carry[gi];
            genvar gj;
            for (gj = 0; gj < 4; gj++) begin : g_bit
                assign raw_sum[gi*4+gj] = p[gi*4+gj] ^ rc[gj];
                assign rc[gj+1] = g[gi*4+gj] | (p[gi*4+gj] & rc[gj]);
            end
            // Skip path: a fully propagating block passes its carry-in straight through.
            assign block_carry[gi+1] = (&p[gi*4 +: 4]) ? block_carry[gi] : rc[4];
        end
    endgenerate

    assign sum  = rst ? '0 : raw_sum;
    assign cout = rst ? 1'b0 : block_carry[NB];

endmodule

// File: rtl/multiword_serial_adder.sv
// Wide adder/subtractor that streams one N-bit chunk per cycle, LSB first, through
// a single carry-skip slice, keeping the inter-chunk carry in a flop.
module multiword_serial_adder
    import multiword_serial_adder_pkg::*;
#(
    parameter int N      = 16,
    parameter int CHUNKS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N*CHUNKS-1:0] in_a,
    input  logic [N*CHUNKS-1:0] in_b,
    input  logic                in_cin,
    input  logic                in_sub,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N*CHUNKS-1:0] out_sum,
    output logic                out_cout,
    output logic                busy
);
    localparam int W  = N * CHUNKS;
    localparam int IW = idx_width(CHUNKS);
    localparam logic [IW-1:0] LAST_IDX = IW'(CHUNKS - 1);

    state_t        state_reg;
    logic          in_ready_reg;
    logic          out_valid_reg;
    logic          busy_reg;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic          carry_reg;
    logic [IW-1:0] idx_reg;
    logic [N-1:0]  result_reg [CHUNKS];

    logic [N-1:0]  a_words [CHUNKS];
    logic [N-1:0]  b_words [CHUNKS];
    logic [N-1:0]  slice_sum;
    logic          slice_cout;

    genvar gi;
    generate
        for (gi = 0; gi < CHUNKS; gi++) begin : g_words
            assign a_words[gi]          = a_reg[gi*N +: N];
            assign b_words[gi]          = b_reg[gi*N +: N];
            assign out_sum[gi*N +: N]   = result_reg[gi];
        end
    endgenerate

    top_carry_skip_adder #(.N(N)) u_chunk_adder (
        .rst  (1'b0),
        .a    (a_words[idx_reg]),
        .b    (b_words[idx_reg]),
        .cin  (carry_reg),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            a_reg         <= '0;
            b_reg         <= '0;
            carry_reg     <= 1'b0;
            idx_reg       <= '0;
            for (int i = 0; i < CHUNKS; i++) result_reg[i] <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction is A + ~B + 1; the inversion is done once at latch time.
                        a_reg        <= in_a;
                        b_reg        <= in_sub ? ~in_b : in_b;
                        carry_reg    <= in_sub | in_cin;
                        idx_reg      <= '0;
                        for (int i = 0; i < CHUNKS; i++) result_reg[i] <= '0;
                        state_reg    <= ADD;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                    end
                end
                ADD: begin
                    result_reg[idx_reg] <= slice_sum;
                    carry_reg           <= slice_cout;
                    if (idx_reg == LAST_IDX) begin
                        idx_reg       <= '0;
                        state_reg     <= DONE;
                        out_valid_reg <= 1'b1;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        in_ready_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign busy      = busy_reg;
    assign out_cout  = out_valid_reg ? carry_reg : 1'b0;

endmodule

// File: tb/tb_multiword_serial_adder.sv
// Directed and randomized checks of multiword_serial_adder against a 65-bit
// arithmetic reference (N=16, CHUNKS=4).
module tb_multiword_serial_adder;
    localparam int N      = 16;
    localparam int CHUNKS = 4;
    localparam int W      = N * CHUNKS;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_cin = 1'b0;
    logic         in_sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    multiword_serial_adder #(.N(N), .CHUNKS(CHUNKS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: plain wide arithmetic; subtraction as A - B + 2^W so bit W is "no borrow".
    function automatic logic [W:0] golden(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin, input logic sub);
        logic [W:0] two_w;
        two_w = {1'b1, {W{1'b0}}};
        if (sub) return {1'b0, a} + two_w - {1'b0, b};
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    endfunction

    // Drives one transaction, scrambles inputs after acceptance, waits for the result,
    // stalls out_ready for 'stall' cycles, then takes it.
    task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                           input logic s, input int stall, output logic [W-1:0] sum,
                           output logic cout, output int lat, output bit ok);
        int wait_n;
        ok = 1'b1; wait_n = 0; lat = 0; sum = '0; cout = 1'b0;
        @(negedge clk);
        while (!in_ready && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        if (!in_ready) begin
            ok = 1'b0;
            return;
        end
        in_valid = 1'b1; in_a = a; in_b = b; in_cin = c; in_sub = s;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
        in_cin = 1'($urandom); in_sub = 1'($urandom);
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 50);
        if (!out_valid) begin
            ok = 1'b0;
            return;
        end
        sum = out_sum; cout = out_cout;
        repeat (stall) @(posedge clk);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, busy, out_cout} !== 4'b1000) begin
            failures++;
            $display("FAIL reset_flags got ready/valid/busy/cout=%b required 1000",
                     {in_ready, out_valid, busy, out_cout});
        end
        checks++;
        if (out_sum !== '0) begin
            failures++;
            $display("FAIL reset_sum got %h required 0", out_sum);
        end
        @(negedge clk);
        rst = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_chunk_carry();
        logic [W-1:0] s; logic c; int lat; bit ok;
        run_txn(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 0, s, c, lat, ok);
        checks++;
        if (!ok || s !== 64'h0000_0000_0001_0000 || c !== 1'b0) begin
            failures++;
            $display("FAIL chunk_carry got ok=%0d sum=%h cout=%b required sum=0000000000010000 cout=0",
                     ok, s, c);
        end
        checks++;
        if (lat !== CHUNKS) begin
            failures++;
            $display("FAIL latency got %0d required %0d", lat, CHUNKS);
        end
        $display("test_chunk_carry sum=%h cout=%b lat=%0d", s, c, lat);
    endtask

    task automatic test_full_ripple();
        logic [W-1:0] s; logic c; int lat; bit ok;
        run_txn(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 0, s, c, lat, ok);
        checks++;
        if (!ok || s !== '0 || c !== 1'b1) begin
            failures++;
            $display("FAIL full_ripple got ok=%0d sum=%h cout=%b required sum=0 cout=1", ok, s, c);
        end
        $display("test_full_ripple sum=%h cout=%b", s, c);
    endtask

    task automatic test_subtract();
        logic [W-1:0] s; logic c; int lat; bit ok;
        run_txn(64'h5, 64'h7, 1'b1, 1'b1, 0, s, c, lat, ok);
        checks++;
        if (!ok || s !== 64'hFFFF_FFFF_FFFF_FFFE || c !== 1'b0) begin
            failures++;
            $display("FAIL sub_borrow got ok=%0d sum=%h cout=%b required sum=fffffffffffffffe cout=0",
                     ok, s, c);
        end
        $display("test_subtract 5-7 sum=%h cout=%b", s, c);
        run_txn(64'h7, 64'h5, 1'b0, 1'b1, 0, s, c, lat, ok);
        checks++;
        if (!ok || s !== 64'h2 || c !== 1'b1) begin
            failures++;
            $display("FAIL sub_noborrow got ok=%0d sum=%h cout=%b required sum=2 cout=1", ok, s, c);
        end
        $display("test_subtract 7-5 sum=%h cout=%b", s, c);
    endtask

    task automatic test_backpressure();
        int lat; int bad;
        logic [W-1:0] s; logic c; bit ok;
        @(negedge clk);
        in_valid = 1'b1; in_a = 64'h1234_5678_9ABC_DEF0; in_b = 64'h0FED_CBA9_8765_4321;
        in_cin = 1'b1; in_sub = 1'b0;
        @(posedge clk);
        #1;
        // Keep offering a second pair: it must not be taken until the result leaves.
        in_a = 64'h3; in_b = 64'h4; in_cin = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 50);
        checks++;
        if (!out_valid || lat !== CHUNKS) begin
            failures++;
            $display("FAIL bp_latency got valid=%b lat=%0d required valid=1 lat=%0d", out_valid, lat, CHUNKS);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (!out_valid || out_sum !== 64'h2222_2222_2222_2212 || out_cout !== 1'b0 || in_ready !== 1'b0)
                bad++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL bp_hold got %0d unstable cycles (sum=%h cout=%b ready=%b) required 0",
                     bad, out_sum, out_cout, in_ready);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL bp_release got ready=%b valid=%b busy=%b required 1 0 0", in_ready, out_valid, busy);
        end
        // in_valid still high: the pending pair is accepted on the next edge.
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_accept got ready=%b busy=%b required 0 1", in_ready, busy);
        end
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 50);
        s = out_sum; c = out_cout; ok = out_valid;
        checks++;
        if (!ok || s !== 64'h7 || c !== 1'b0) begin
            failures++;
            $display("FAIL b2b_result got valid=%b sum=%h cout=%b required sum=7 cout=0", ok, s, c);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        $display("test_backpressure hold_bad=%0d b2b_sum=%h", bad, s);
    endtask

    task automatic test_reset_mid_add();
        logic [W-1:0] s; logic c; int lat; bit ok;
        @(negedge clk);
        in_valid = 1'b1; in_a = 64'hFFFF_FFFF_FFFF_FFFF; in_b = 64'hFFFF_FFFF_FFFF_FFFF;
        in_cin = 1'b1; in_sub = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, busy, out_cout} !== 4'b1000 || out_sum !== '0) begin
            failures++;
            $display("FAIL reset_mid_add got ready/valid/busy/cout=%b sum=%h required 1000 sum=0",
                     {in_ready, out_valid, busy, out_cout}, out_sum);
        end
        @(negedge clk);
        rst = 1'b0;
        run_txn(64'h1, 64'h1, 1'b0, 1'b0, 0, s, c, lat, ok);
        checks++;
        if (!ok || s !== 64'h2 || c !== 1'b0) begin
            failures++;
            $display("FAIL after_reset got ok=%0d sum=%h cout=%b required sum=2 cout=0", ok, s, c);
        end
        $display("test_reset_mid_add next_sum=%h cout=%b", s, c);
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, s; logic cin, sub, c; int lat; bit ok;
        logic [W:0] exp_v;
        int results, errs;
        results = 0; errs = 0;
        for (int t = 0; t < 1000; t++) begin
            a = {$urandom, $urandom}; b = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) a = '1;
            if ($urandom_range(0, 7) == 0) b = (t % 2 == 0) ? a : ~a;
            cin = 1'($urandom); sub = 1'($urandom);
            exp_v = golden(a, b, cin, sub);
            run_txn(a, b, cin, sub, $urandom_range(0, 3), s, c, lat, ok);
            if (ok) results++;
            checks++;
            if (!ok || {c, s} !== exp_v || lat !== CHUNKS) begin
                failures++; errs++;
                $display("FAIL random_%0d got ok=%0d cout=%b sum=%h lat=%0d required cout=%b sum=%h lat=%0d",
                         t, ok, c, s, lat, exp_v[W], exp_v[W-1:0], CHUNKS);
            end
            checks++;
            if (out_valid !== 1'b0) begin
                failures++; errs++;
                $display("FAIL random_dup_%0d got out_valid=%b after take required 0", t, out_valid);
            end
        end
        checks++;
        if (results != 1000) begin
            failures++;
            $display("FAIL random_count got %0d results required 1000", results);
        end
        $display("test_random results=%0d errors=%0d", results, errs);
    endtask

    initial begin
        test_reset();
        test_chunk_carry();
        test_full_ripple();
        test_subtract();
        test_backpressure();
        test_reset_mid_add();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
